// File: rtl/led_pattern_pkg.sv
// Shared types and constants for the LED pattern engine.
package led_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_COUNT   = 2'd0,
        MODE_SCAN    = 2'd1,
        MODE_BREATHE = 2'd2,
        MODE_FILL    = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Each speed step multiplies the prescaler period by 2**SPEED_SHIFT.
    localparam int unsigned SPEED_SHIFT = 2;

endpackage

// File: rtl/led_tick_div.sv
// Pattern-rate prescaler with pause/single-step gating; emits a registered
// one-cycle tick per pattern advance.
module led_tick_div
    import led_pattern_pkg::*;
#(
    parameter int unsigned BASE_DIV = 1048576
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] speed,
    input  logic       pause,
    input  logic       step,
    input  logic       clear,
    output logic       tick
);
    localparam int unsigned PRE_W = $clog2(64'(BASE_DIV) << (SPEED_SHIFT * 3));

    logic [PRE_W-1:0] pre_q, pre_d, limit;
    logic             wrap, adv, tick_q;

    always_comb begin
        limit = (PRE_W'(BASE_DIV) << (SPEED_SHIFT * 32'(speed))) - PRE_W'(1);
        // >= so that lowering the speed mid-count wraps at once
        wrap  = (pre_q >= limit);
        adv   = ~clear & ((wrap & ~pause) | (step & pause));
        pre_d = pre_q;
        if (clear) begin
            pre_d = '0;
        end else if (!pause) begin
            pre_d = wrap ? '0 : pre_q + PRE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= adv;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern engine: COUNT, SCAN, BREATHE and FILL patterns at a prescaled rate.
// Define LED_PATTERN_PWM_EN to build BREATHE; otherwise mode 2 behaves as COUNT.
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int unsigned LED_W    = 8,
    parameter int unsigned BASE_DIV = 1048576,
    parameter int unsigned PWM_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic [1:0]       speed,
    input  logic             pause,
    input  logic             step,
    output logic [LED_W-1:0] led,
    output logic             tick
);
    localparam int unsigned      POS_W    = $clog2(LED_W);
    localparam int unsigned      LVL_W    = $clog2(LED_W + 1);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(LED_W - 1);
    localparam logic [POS_W-1:0] POS_PREV = POS_W'(LED_W - 2);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(LED_W);

    if (LED_W < 2 || LED_W > 32 || BASE_DIV < 1 || PWM_W < 1) begin : g_bad_param
        $error("led_pattern_gen: parameter out of range");
    end

    mode_e            mode_q, mode_d, eff_mode;
    logic             mode_chg;
    logic [LED_W-1:0] count_q, count_d, led_q, led_d;
    logic [POS_W-1:0] pos_q, pos_d;
    dir_e             dir_q, dir_d;
    logic [LVL_W-1:0] level_q, level_d;
`ifdef LED_PATTERN_PWM_EN
    logic [PWM_W-1:0] duty_q, duty_d, pwm_q, pwm_d;
    dir_e             duty_dir_q, duty_dir_d;
`endif

    assign mode_chg = (mode_e'(mode) != mode_q);

    led_tick_div #(
        .BASE_DIV(BASE_DIV)
    ) u_tick_div (
        .clk  (clk),
        .reset(reset),
        .speed(speed),
        .pause(pause),
        .step (step),
        .clear(mode_chg),
        .tick (tick)
    );

`ifdef LED_PATTERN_PWM_EN
    assign eff_mode = mode_q;
`else
    assign eff_mode = (mode_q == MODE_BREATHE) ? MODE_COUNT : mode_q;
`endif

    always_comb begin
        mode_d  = mode_q;
        count_d = count_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        level_d = level_q;
`ifdef LED_PATTERN_PWM_EN
        duty_d     = duty_q;
        duty_dir_d = duty_dir_q;
        pwm_d      = mode_chg ? '0 : pwm_q + PWM_W'(1);
`endif
        if (mode_chg) begin
            mode_d  = mode_e'(mode);
            count_d = '0;
            pos_d   = '0;
            dir_d   = DIR_UP;
            level_d = '0;
`ifdef LED_PATTERN_PWM_EN
            duty_d     = '0;
            duty_dir_d = DIR_UP;
`endif
        end else if (tick) begin
            case (eff_mode)
                // End positions turn around without repeating the end LED
                MODE_SCAN: begin
                    if (dir_q == DIR_UP) begin
                        if (pos_q == POS_LAST) begin
                            pos_d = POS_PREV;
                            dir_d = DIR_DOWN;
                        end else begin
                            pos_d = pos_q + POS_W'(1);
                        end
                    end else begin
                        if (pos_q == '0) begin
                            pos_d = POS_W'(1);
                            dir_d = DIR_UP;
                        end else begin
                            pos_d = pos_q - POS_W'(1);
                        end
                    end
                end
                MODE_FILL: level_d = (level_q == LVL_FULL) ? '0 : level_q + LVL_W'(1);
`ifdef LED_PATTERN_PWM_EN
                MODE_BREATHE: begin
                    if (duty_dir_q == DIR_UP) begin
                        if (duty_q == '1) begin
                            duty_d     = duty_q - PWM_W'(1);
                            duty_dir_d = DIR_DOWN;
                        end else begin
                            duty_d = duty_q + PWM_W'(1);
                        end
                    end else begin
                        if (duty_q == '0) begin
                            duty_d     = PWM_W'(1);
                            duty_dir_d = DIR_UP;
                        end else begin
                            duty_d = duty_q - PWM_W'(1);
                        end
                    end
                end
`endif
                default: count_d = count_q + LED_W'(1);
            endcase
        end
    end

    always_comb begin
        led_d = count_q;
        case (eff_mode)
            MODE_SCAN: led_d = LED_W'(1) << pos_q;
            MODE_FILL: begin
                for (int unsigned i = 0; i < LED_W; i++) begin
                    led_d[i] = (i < 32'(level_q));
                end
            end
`ifdef LED_PATTERN_PWM_EN
            MODE_BREATHE: led_d = {LED_W{pwm_q < duty_q}};
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q  <= MODE_COUNT;
            count_q <= '0;
            pos_q   <= '0;
            dir_q   <= DIR_UP;
            level_q <= '0;
            led_q   <= '0;
`ifdef LED_PATTERN_PWM_EN
            duty_q     <= '0;
            duty_dir_q <= DIR_UP;
            pwm_q      <= '0;
`endif
        end else begin
            mode_q  <= mode_d;
            count_q <= count_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            level_q <= level_d;
            led_q   <= led_d;
`ifdef LED_PATTERN_PWM_EN
            duty_q     <= duty_d;
            duty_dir_q <= duty_dir_d;
            pwm_q      <= pwm_d;
`endif
        end
    end

    assign led = led_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed self-checking bench for led_pattern_gen (BASE_DIV=4, LED_W=8, PWM_W=8).
module tb_led_pattern_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] mode;
    logic [1:0] speed;
    logic       pause;
    logic       step;
    logic [7:0] led;
    logic       tick;

    int tests = 0;
    int fails = 0;

    led_pattern_gen #(
        .LED_W   (8),
        .BASE_DIV(4),
        .PWM_W   (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .mode (mode),
        .speed(speed),
        .pause(pause),
        .step (step),
        .led  (led),
        .tick (tick)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: observed no finish, expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step_clk();
            n++;
        end while (tick !== 1'b1 && n < 1000);
    endtask

    task automatic adv_led(output int n, output logic [7:0] l);
        wait_tick(n);
        step_clk();
        step_clk();
        l = led;
    endtask

    logic [7:0] scan_exp [16] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                                  8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
    logic [7:0] fill_exp [10] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                                  8'h00, 8'h01};

    initial begin
        int         n;
        int         cnt_a;
        int         cnt_b;
        logic [7:0] l;

        reset = 1'b0;
        mode  = 2'd0;
        speed = 2'd0;
        pause = 1'b0;
        step  = 1'b0;
        #2 reset = 1'b1;
        step_clk();
        step_clk();
        check("rst_led", led, 8'h00);
        check("rst_tick", tick, 1'b0);
        reset = 1'b0;

        // COUNT
        adv_led(n, l);
        check("count_first_tick_latency", n, 4);
        check("count_led1", l, 8'h01);
        wait_tick(n);
        wait_tick(n);
        check("count_tick_spacing", n, 4);
        step_clk();
        step_clk();
        check("count_led3", led, 8'h03);
        for (int i = 0; i < 252; i++) adv_led(n, l);
        check("count_led_ff", l, 8'hFF);
        adv_led(n, l);
        check("count_wrap", l, 8'h00);
        for (int i = 0; i < 5; i++) adv_led(n, l);
        check("count_led5", l, 8'h05);

        // Pause / step
        pause = 1'b1;
        cnt_a = 0;
        for (int i = 0; i < 100; i++) begin
            step_clk();
            if (tick === 1'b1) cnt_a++;
        end
        check("pause_no_ticks", cnt_a, 0);
        check("pause_hold_led", led, 8'h05);
        for (int i = 0; i < 3; i++) begin
            step = 1'b1;
            step_clk();
            step = 1'b0;
            check($sformatf("step_tick%0d", i), tick, 1'b1);
            step_clk();
            step_clk();
            step_clk();
        end
        check("step_led8", led, 8'h08);
        pause = 1'b0;
        step  = 1'b1;
        step_clk();
        step  = 1'b0;
        check("step_unpaused_ignored", tick, 1'b0);
        wait_tick(n);
        check("resume_tick_latency", n, 1);
        step_clk();
        step_clk();
        check("resume_led9", led, 8'h09);

        // SCAN
        mode = 2'd1;
        step_clk();
        step_clk();
        check("scan_entry_led", led, 8'h01);
        wait_tick(n);
        check("scan_first_tick_latency", n, 3);
        step_clk();
        step_clk();
        check("scan_step0", led, scan_exp[0]);
        for (int i = 1; i < 16; i++) begin
            adv_led(n, l);
            check($sformatf("scan_step%0d", i), l, scan_exp[i]);
        end

        // FILL
        mode = 2'd3;
        step_clk();
        step_clk();
        check("fill_entry_led", led, 8'h00);
        for (int i = 0; i < 10; i++) begin
            adv_led(n, l);
            check($sformatf("fill_step%0d", i), l, fill_exp[i]);
        end

        // Speed
        speed = 2'd1;
        wait_tick(n);
        wait_tick(n);
        check("speed1_spacing", n, 16);
        speed = 2'd3;
        wait_tick(n);
        wait_tick(n);
        check("speed3_spacing", n, 256);
        for (int i = 0; i < 40; i++) step_clk();
        check("speed3_no_tick_at_pre40", tick, 1'b0);
        speed = 2'd0;
        step_clk();
        check("speed_drop_immediate_wrap", tick, 1'b1);

        // BREATHE (or COUNT alias without the PWM build)
        mode = 2'd2;
        step_clk();
        step_clk();
        check("breathe_entry_led", led, 8'h00);
        for (int i = 0; i < 128; i++) adv_led(n, l);
        pause = 1'b1;
        cnt_a = 0;
        cnt_b = 0;
`ifdef LED_PATTERN_PWM_EN
        for (int i = 0; i < 256; i++) begin
            step_clk();
            if (led === 8'hFF) cnt_a++;
            if (led === 8'h00) cnt_b++;
        end
        check("breathe_on_clocks", cnt_a, 128);
        check("breathe_off_clocks", cnt_b, 128);
`else
        for (int i = 0; i < 256; i++) begin
            step_clk();
            if (led === 8'h80) cnt_a++;
        end
        check("mode2_as_count_led80", cnt_a, 256);
        check("mode2_as_count_last", led, 8'h80);
`endif
        pause = 1'b0;

        // Reset mid-SCAN
        mode = 2'd1;
        step_clk();
        step_clk();
        for (int i = 0; i < 5; i++) adv_led(n, l);
        check("scan_pos5_led", l, 8'h20);
        wait_tick(n);
        check("tick_before_reset", tick, 1'b1);
        reset = 1'b1;
        #1;
        check("async_reset_tick", tick, 1'b0);
        check("async_reset_led", led, 8'h00);
        step_clk();
        step_clk();
        step_clk();
        check("reset_hold_led", led, 8'h00);
        reset = 1'b0;
        step_clk();
        check("post_reset_led0", led, 8'h00);
        step_clk();
        check("post_reset_scan_led", led, 8'h01);
        adv_led(n, l);
        check("post_reset_scan_next", l, 8'h02);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
